// File: rtl/fpu_mul_ctrl.sv
// Issue/sequencing controller for the single-precision multiply datapath.
// Unpacks operands and aligns exponent/sideband with the multiplier; results are returned in order through a credit-limited FIFO.
module fpu_mul_ctrl #(
    parameter int unsigned MUL_LAT    = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TAG_W      = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [23:0]      dp_sig_a,
    output logic [23:0]      dp_sig_b,
    output logic [8:0]       dp_pre_exp,
    output logic             dp_exp_uf,
    input  logic [25:0]      dp_sig,
    input  logic [7:0]       dp_exp,
    input  logic             dp_of,
    input  logic             dp_uf,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_sign,
    output logic [25:0]      res_sig,
    output logic [7:0]       res_exp,
    output logic             res_of,
    output logic             res_uf,
    output logic [1:0]       res_special,
    output logic             res_nv,
    output logic [TAG_W-1:0] res_tag,
    output logic             busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned OW = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] SP_NORM = 2'b00;
    localparam logic [1:0] SP_ZERO = 2'b01;
    localparam logic [1:0] SP_INF  = 2'b10;
    localparam logic [1:0] SP_NAN  = 2'b11;

    typedef struct packed {
        logic             valid;
        logic [8:0]       pre_exp;
        logic             exp_uf;
        logic             sign;
        logic [1:0]       special;
        logic             nv;
        logic [TAG_W-1:0] tag;
    } side_t;

    typedef struct packed {
        logic             sign;
        logic [25:0]      sig;
        logic [7:0]       exp;
        logic             of;
        logic             uf;
        logic [1:0]       special;
        logic             nv;
        logic [TAG_W-1:0] tag;
    } res_t;

    logic [OW-1:0] r_occ;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    side_t         r_iss;
    logic [23:0]   r_sig_a;
    logic [23:0]   r_sig_b;
    side_t         r_dl [1:MUL_LAT];
    res_t          r_mem [FIFO_DEPTH];

    logic [7:0]    w_exp_a, w_exp_b;
    logic [22:0]   w_man_a, w_man_b;
    logic          w_nan_a, w_nan_b, w_snan_a, w_snan_b;
    logic          w_inf_a, w_inf_b, w_zero_a, w_zero_b, w_inf_zero;
    logic [7:0]    w_eff_a, w_eff_b;
    logic [9:0]    w_sum;
    side_t         w_iss;
    side_t         w_tail;
    res_t          w_entry;
    res_t          w_head;
    logic          w_acc, w_pop, w_cap;
    logic [PW-1:0] w_fifo_cnt;

    // Operand unpack and special-case classification
    assign w_exp_a    = in_a[30:23];
    assign w_exp_b    = in_b[30:23];
    assign w_man_a    = in_a[22:0];
    assign w_man_b    = in_b[22:0];
    assign w_nan_a    = (w_exp_a == 8'hFF) && (w_man_a != 23'd0);
    assign w_nan_b    = (w_exp_b == 8'hFF) && (w_man_b != 23'd0);
    assign w_snan_a   = w_nan_a && !w_man_a[22];
    assign w_snan_b   = w_nan_b && !w_man_b[22];
    assign w_inf_a    = (w_exp_a == 8'hFF) && (w_man_a == 23'd0);
    assign w_inf_b    = (w_exp_b == 8'hFF) && (w_man_b == 23'd0);
    assign w_zero_a   = (w_exp_a == 8'd0) && (w_man_a == 23'd0);
    assign w_zero_b   = (w_exp_b == 8'd0) && (w_man_b == 23'd0);
    assign w_inf_zero = (w_inf_a && w_zero_b) || (w_inf_b && w_zero_a);

    // Denormals use an effective exponent of 1
    assign w_eff_a = (w_exp_a == 8'd0) ? 8'd1 : w_exp_a;
    assign w_eff_b = (w_exp_b == 8'd0) ? 8'd1 : w_exp_b;
    assign w_sum   = 10'(w_eff_a) + 10'(w_eff_b);

    always_comb begin
        w_iss         = '0;
        w_iss.valid   = 1'b1;
        w_iss.exp_uf  = (w_sum < 10'd127);
        w_iss.pre_exp = 9'(w_sum - 10'd127);
        w_iss.sign    = in_a[31] ^ in_b[31];
        w_iss.nv      = w_inf_zero || w_snan_a || w_snan_b;
        w_iss.tag     = in_tag;
        if (w_nan_a || w_nan_b || w_inf_zero) begin
            w_iss.special = SP_NAN;
        end else if (w_inf_a || w_inf_b) begin
            w_iss.special = SP_INF;
        end else if (w_zero_a || w_zero_b) begin
            w_iss.special = SP_ZERO;
        end else begin
            w_iss.special = SP_NORM;
        end
    end

    // FIFO entry: specials override the datapath result
    assign w_tail = r_dl[MUL_LAT];
    always_comb begin
        w_entry         = '0;
        w_entry.sign    = w_tail.sign && (w_tail.special != SP_NAN);
        w_entry.special = w_tail.special;
        w_entry.nv      = w_tail.nv;
        w_entry.tag     = w_tail.tag;
        if (w_tail.special == SP_NORM) begin
            w_entry.sig = dp_sig;
            w_entry.exp = dp_exp;
            w_entry.of  = dp_of;
            w_entry.uf  = dp_uf;
        end else begin
            w_entry.exp = w_tail.special[1] ? 8'hFF : 8'h00;
        end
    end

    assign in_ready   = !flush && (r_occ < OW'(FIFO_DEPTH));
    assign w_acc      = in_valid && in_ready;
    assign w_pop      = res_valid && res_ready;
    assign w_cap      = w_tail.valid;
    assign w_fifo_cnt = r_wr_ptr - r_rd_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_occ    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_iss    <= '0;
            r_sig_a  <= '0;
            r_sig_b  <= '0;
            for (int unsigned k = 1; k <= MUL_LAT; k++) begin
                r_dl[k] <= '0;
            end
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_occ       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_iss.valid <= 1'b0;
            for (int unsigned k = 1; k <= MUL_LAT; k++) begin
                r_dl[k].valid <= 1'b0;
            end
        end else begin
            if (w_acc) begin
                r_iss   <= w_iss;
                r_sig_a <= {(|w_exp_a), w_man_a};
                r_sig_b <= {(|w_exp_b), w_man_b};
            end else begin
                r_iss.valid <= 1'b0;
            end
            r_dl[1] <= r_iss;
            for (int unsigned k = 2; k <= MUL_LAT; k++) begin
                r_dl[k] <= r_dl[k-1];
            end
            if (w_cap) begin
                r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
                r_wr_ptr                <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_acc && !w_pop) begin
                r_occ <= r_occ + OW'(1);
            end else if (!w_acc && w_pop) begin
                r_occ <= r_occ - OW'(1);
            end
        end
    end

    // Credits must keep a capture from ever landing in a full FIFO
    always @(posedge clk) begin
        if (!reset && !flush && w_cap) begin
            assert (w_fifo_cnt != PW'(FIFO_DEPTH));
        end
    end

    assign dp_sig_a   = r_sig_a;
    assign dp_sig_b   = r_sig_b;
    assign dp_pre_exp = w_tail.pre_exp;
    assign dp_exp_uf  = w_tail.exp_uf;

    assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
    assign res_valid   = (r_wr_ptr != r_rd_ptr);
    assign res_sign    = w_head.sign;
    assign res_sig     = w_head.sig;
    assign res_exp     = w_head.exp;
    assign res_of      = w_head.of;
    assign res_uf      = w_head.uf;
    assign res_special = w_head.special;
    assign res_nv      = w_head.nv;
    assign res_tag     = w_head.tag;
    assign busy        = (r_occ != '0);

endmodule

// File: tb/tb_fpu_mul_ctrl.sv
// Directed bench for fpu_mul_ctrl with a behavioural stand-in for the multiply datapath.
module tb_fpu_mul_ctrl;

    localparam int unsigned MUL_LAT    = 2;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned TAG_W      = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_a = '0;
    logic [31:0]      in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [23:0]      dp_sig_a, dp_sig_b;
    logic [8:0]       dp_pre_exp;
    logic             dp_exp_uf;
    logic [25:0]      dp_sig;
    logic [7:0]       dp_exp;
    logic             dp_of, dp_uf;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic             res_sign;
    logic [25:0]      res_sig;
    logic [7:0]       res_exp;
    logic             res_of, res_uf;
    logic [1:0]       res_special;
    logic             res_nv;
    logic [TAG_W-1:0] res_tag;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    fpu_mul_ctrl #(.MUL_LAT(MUL_LAT), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .dp_sig_a(dp_sig_a), .dp_sig_b(dp_sig_b), .dp_pre_exp(dp_pre_exp), .dp_exp_uf(dp_exp_uf),
        .dp_sig(dp_sig), .dp_exp(dp_exp), .dp_of(dp_of), .dp_uf(dp_uf),
        .res_valid(res_valid), .res_ready(res_ready), .res_sign(res_sign), .res_sig(res_sig),
        .res_exp(res_exp), .res_of(res_of), .res_uf(res_uf), .res_special(res_special),
        .res_nv(res_nv), .res_tag(res_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: MUL_LAT-deep product pipe plus a one-step normaliser
    logic [47:0] r_pipe [MUL_LAT];
    logic [47:0] w_prod;
    always @(posedge clk) begin
        r_pipe[0] <= 48'(dp_sig_a) * 48'(dp_sig_b);
        for (int k = 1; k < int'(MUL_LAT); k++) r_pipe[k] <= r_pipe[k-1];
    end
    assign w_prod = r_pipe[MUL_LAT-1];
    assign dp_sig = w_prod[47] ? w_prod[47:22] : w_prod[46:21];
    assign dp_exp = dp_pre_exp[7:0] + 8'(w_prod[47]);
    assign dp_uf  = dp_exp_uf;
    assign dp_of  = !dp_exp_uf && dp_pre_exp[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Present one operand pair; acc reports whether it was taken at the next edge
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t,
                        output logic acc);
        @(negedge clk);
        in_a = a; in_b = b; in_tag = t; in_valid = 1'b1;
        #1 acc = in_ready;
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Step whole cycles (negedge to negedge) until res_valid, bounded by budget
    task automatic wait_res(input string name, input int budget, output int cyc);
        cyc = 0;
        while (!res_valid && cyc < budget) begin
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        if (!res_valid) check({name, "_timeout"}, 32'(res_valid), 32'd1);
    endtask

    initial begin
        logic acc;
        int   lat;
        int   cyc;
        logic seen;
        int   n_acc;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_pre_exp",   32'(dp_pre_exp), 32'd0);
        check("rst_sig_a",     32'(dp_sig_a),  32'd0);
        check("rst_res_tag",   32'(res_tag),   32'd0);

        // 1.5 * 2.0: latency and aligned exponent
        res_ready = 1'b1;
        send(32'h3FC0_0000, 32'h4000_0000, 3'd2, acc);
        check("t1_acc", 32'(acc), 32'd1);
        idle();
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); @(negedge clk);
            if (k == int'(MUL_LAT) + 1) begin
                check("t1_pre_exp", 32'(dp_pre_exp), 32'd128);
                check("t1_exp_uf",  32'(dp_exp_uf),  32'd0);
            end
            if (res_valid) begin
                lat = k + 1;
                break;
            end
        end
        check("t1_latency", 32'(lat), 32'(MUL_LAT + 2));
        check("t1_exp",     32'(res_exp),     32'd128);
        check("t1_sig",     32'(res_sig),     32'h300_0000);
        check("t1_sign",    32'(res_sign),    32'd0);
        check("t1_special", 32'(res_special), 32'd0);
        check("t1_tag",     32'(res_tag),     32'd2);
        @(posedge clk); @(negedge clk);
        check("t1_drained", 32'(res_valid), 32'd0);
        check("t1_busy",    32'(busy),      32'd0);

        // inf * 0 then -1.5 * 2.0, strictly in order
        send(32'h7F80_0000, 32'h0000_0000, 3'd1, acc);
        send(32'hBFC0_0000, 32'h4000_0000, 3'd5, acc);
        idle();
        wait_res("t2", 10, cyc);
        check("t2_special", 32'(res_special), 32'd3);
        check("t2_nv",      32'(res_nv),      32'd1);
        check("t2_exp",     32'(res_exp),     32'hFF);
        check("t2_sig",     32'(res_sig),     32'd0);
        check("t2_tag",     32'(res_tag),     32'd1);
        @(posedge clk); @(negedge clk);
        check("t2b_valid",   32'(res_valid),   32'd1);
        check("t2b_tag",     32'(res_tag),     32'd5);
        check("t2b_sign",    32'(res_sign),    32'd1);
        check("t2b_special", 32'(res_special), 32'd0);
        check("t2b_exp",     32'(res_exp),     32'd128);
        check("t2b_nv",      32'(res_nv),      32'd0);
        @(posedge clk); @(negedge clk);
        check("t2_drained", 32'(res_valid), 32'd0);

        // Backpressure: six requests, only four credits
        res_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            send(32'h3F80_0000, 32'h3F80_0000, 3'(i), acc);
            check($sformatf("t3_acc%0d", i), 32'(acc), (i < 4) ? 32'd1 : 32'd0);
            if (acc) n_acc++;
        end
        idle();
        check("t3_n_acc",   32'(n_acc),    32'd4);
        check("t3_in_rdy0", 32'(in_ready), 32'd0);
        check("t3_busy",    32'(busy),     32'd1);
        repeat (6) @(negedge clk);
        res_ready = 1'b1;
        #1 check("t3_no_comb_rdy", 32'(in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_valid%0d", i), 32'(res_valid), 32'd1);
            check($sformatf("t3_tag%0d", i),   32'(res_tag),   32'(i));
            @(posedge clk); @(negedge clk);
            if (i == 0) check("t3_in_rdy1", 32'(in_ready), 32'd1);
        end
        check("t3_drained", 32'(res_valid), 32'd0);

        // Exponent underflow: 27 + 97 - 127 = -3
        send(32'h0DC0_0000, 32'h3080_0000, 3'd4, acc);
        idle();
        for (int k = 1; k <= int'(MUL_LAT) + 1; k++) begin
            @(posedge clk); @(negedge clk);
        end
        check("t4_exp_uf",  32'(dp_exp_uf),  32'd1);
        check("t4_pre_exp", 32'(dp_pre_exp), 32'h1FD);
        wait_res("t4", 5, cyc);
        check("t4_uf",  32'(res_uf),  32'd1);
        check("t4_of",  32'(res_of),  32'd0);
        check("t4_exp", 32'(res_exp), 32'hFD);
        check("t4_tag", 32'(res_tag), 32'd4);
        @(posedge clk); @(negedge clk);

        // Flush with three operations in flight
        send(32'h3FC0_0000, 32'h4000_0000, 3'd1, acc);
        send(32'h3FC0_0000, 32'h4000_0000, 3'd2, acc);
        send(32'h3FC0_0000, 32'h4000_0000, 3'd3, acc);
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b1;
        #1 check("t5_rdy_in_flush", 32'(in_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("t5_valid", 32'(res_valid), 32'd0);
        check("t5_busy",  32'(busy),      32'd0);
        check("t5_rdy",   32'(in_ready),  32'd1);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); @(negedge clk);
            seen = seen | res_valid;
        end
        check("t5_no_stale", 32'(seen), 32'd0);
        send(32'h3FC0_0000, 32'h4000_0000, 3'd6, acc);
        idle();
        wait_res("t5", 10, cyc);
        check("t5_after_tag", 32'(res_tag), 32'd6);
        check("t5_after_exp", 32'(res_exp), 32'd128);
        @(posedge clk); @(negedge clk);

        // Asynchronous reset with two results outstanding
        res_ready = 1'b0;
        send(32'h3FC0_0000, 32'h4000_0000, 3'd1, acc);
        send(32'h3FC0_0000, 32'h4000_0000, 3'd2, acc);
        idle();
        repeat (6) @(negedge clk);
        check("t6_valid_pre", 32'(res_valid), 32'd1);
        check("t6_busy_pre",  32'(busy),      32'd1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("t6_valid_async", 32'(res_valid), 32'd0);
        check("t6_busy_async",  32'(busy),      32'd0);
        @(negedge clk);
        reset = 1'b0;
        res_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); @(negedge clk);
            seen = seen | res_valid;
        end
        check("t6_no_stale", 32'(seen),     32'd0);
        check("t6_busy",     32'(busy),     32'd0);
        check("t6_rdy",      32'(in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
